// File: rtl/wb_stage_pbuf.sv
// rtl/wb_stage_pbuf.sv - write-back stage with head/skid buffer; optional trace via WB_TRACE_EN
module wb_stage_pbuf #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 32,
  localparam int BE_W  = DATA_W / 8,
  localparam int BUS_W = PC_W + BE_W + REG_AW + DATA_W
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            ms_to_ws_valid,
  input  logic [BUS_W-1:0]                ms_to_ws_bus,
  output logic                            ws_allowin,
  input  logic                            rf_ready,
  output logic [1+BE_W+REG_AW+DATA_W-1:0] ws_to_rf_bus,
  output logic                            ws_to_ds_valid,
  output logic [REG_AW-1:0]               ws_to_ds_dest,
  output logic [DATA_W-1:0]               ws_to_ds_data,
  output logic [31:0]                     ws_retire_cnt,
  output logic [PC_W-1:0]                 debug_wb_pc,
  output logic [BE_W-1:0]                 debug_wb_rf_wen,
  output logic [REG_AW-1:0]               debug_wb_rf_wnum,
  output logic [DATA_W-1:0]               debug_wb_rf_wdata
);

  localparam int DEST_LSB = DATA_W;
  localparam int BE_LSB   = DATA_W + REG_AW;
  localparam int PC_LSB   = DATA_W + REG_AW + BE_W;

  logic             h_valid;
  logic             s_valid;
  logic [BUS_W-1:0] h_ent;
  logic [BUS_W-1:0] s_ent;
  logic [31:0]      retire_cnt;

  logic [BUS_W-1:0]  in_ent;
  logic [DATA_W-1:0] h_data;
  logic [REG_AW-1:0] h_dest;
  logic [BE_W-1:0]   h_be;
  logic [PC_W-1:0]   h_pc;
  logic              accept;
  logic              commit;
  logic              h_load;
  logic              s_load;
  logic              we;

  // Head fields, and the incoming entry with byte enables killed for register 0
  always_comb begin
    in_ent = ms_to_ws_bus;
    if (ms_to_ws_bus[DEST_LSB +: REG_AW] == '0) begin
      in_ent[BE_LSB +: BE_W] = '0;
    end
    h_data = h_ent[DATA_W-1:0];
    h_dest = h_ent[DEST_LSB +: REG_AW];
    h_be   = h_ent[BE_LSB +: BE_W];
    h_pc   = h_ent[PC_LSB +: PC_W];
  end

  // Handshake and buffer steering; allowin comes only from the S valid flop
  always_comb begin
    ws_allowin = !s_valid;
    accept     = ms_to_ws_valid && ws_allowin;
    commit     = h_valid && (rf_ready || (h_be == '0));
    we         = commit && (h_be != '0);
    h_load     = !h_valid || commit;
    s_load     = accept && (!h_load || s_valid);
  end

  // Head/skid storage and retired-entry counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      h_valid    <= 1'b0;
      s_valid    <= 1'b0;
      h_ent      <= '0;
      s_ent      <= '0;
      retire_cnt <= '0;
    end else begin
      if (h_load) begin
        if (s_valid) begin
          h_ent <= s_ent;
        end else if (accept) begin
          h_ent <= in_ent;
        end
        h_valid <= s_valid || accept;
      end
      if (s_load) begin
        s_ent   <= in_ent;
        s_valid <= 1'b1;
      end else if (h_load) begin
        s_valid <= 1'b0;
      end
      if (commit) begin
        retire_cnt <= retire_cnt + 32'd1;
      end
    end
  end

  // Register-file port and decode-stage view of the head entry
  always_comb begin
    ws_to_rf_bus   = {we,
                      h_valid ? h_be   : {BE_W{1'b0}},
                      h_valid ? h_dest : {REG_AW{1'b0}},
                      h_valid ? h_data : {DATA_W{1'b0}}};
    ws_to_ds_valid = h_valid;
    ws_to_ds_dest  = (h_valid && (h_be != '0)) ? h_dest : '0;
    ws_to_ds_data  = h_valid ? h_data : '0;
    ws_retire_cnt  = retire_cnt;
  end

`ifdef WB_TRACE_EN
  // Trace shows the head entry only in cycles where it commits
  always_comb begin
    debug_wb_pc       = commit ? h_pc   : '0;
    debug_wb_rf_wen   = commit ? h_be   : '0;
    debug_wb_rf_wnum  = commit ? h_dest : '0;
    debug_wb_rf_wdata = commit ? h_data : '0;
  end
`else
  logic unused_pc;
  assign unused_pc = ^h_pc;

  // Trace disabled: ports kept but tied off
  always_comb begin
    debug_wb_pc       = '0;
    debug_wb_rf_wen   = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
  end
`endif

endmodule

// File: tb/tb_wb_stage_pbuf.sv
// tb/tb_wb_stage_pbuf.sv - scoreboard bench for wb_stage_pbuf
module tb_wb_stage_pbuf;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ms_to_ws_valid;
  logic [72:0] ms_to_ws_bus;
  logic        ws_allowin;
  logic        rf_ready;
  logic [41:0] ws_to_rf_bus;
  logic        ws_to_ds_valid;
  logic [4:0]  ws_to_ds_dest;
  logic [31:0] ws_to_ds_data;
  logic [31:0] ws_retire_cnt;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  always #5 clk = ~clk;

  wb_stage_pbuf dut (
    .clk               (clk),
    .resetn            (resetn),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ws_allowin        (ws_allowin),
    .rf_ready          (rf_ready),
    .ws_to_rf_bus      (ws_to_rf_bus),
    .ws_to_ds_valid    (ws_to_ds_valid),
    .ws_to_ds_dest     (ws_to_ds_dest),
    .ws_to_ds_data     (ws_to_ds_data),
    .ws_retire_cnt     (ws_retire_cnt),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  typedef struct packed {
    logic [3:0]  be;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
    logic        lat;
    logic [31:0] acc;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total    = 0;
  int   ncyc     = 0;

  logic        rf_we;
  logic [3:0]  rf_be;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  assign {rf_we, rf_be, rf_addr, rf_data} = ws_to_rf_bus;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Monitor: pops the scoreboard on every accepted register-file write
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (resetn && rf_we && rf_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {27'd0, rf_addr, rf_data}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_be", {60'd0, rf_be}, {60'd0, e.be});
        chk("wr_addr", {59'd0, rf_addr}, {59'd0, e.addr});
        chk("wr_data", {32'd0, rf_data}, {32'd0, e.data});
        if (e.lat) chk("wr_latency", ncyc, e.acc + 1);
`ifdef WB_TRACE_EN
        chk("dbg_pc", {32'd0, debug_wb_pc}, {32'd0, e.pc});
        chk("dbg_wnum", {59'd0, debug_wb_rf_wnum}, {59'd0, e.addr});
`else
        chk("dbg_tied", {debug_wb_pc, 27'd0, debug_wb_rf_wnum}, 64'd0);
`endif
      end
    end
  end

  task automatic send(input logic [4:0] dest, input logic [3:0] be, input logic [31:0] data, input logic lat);
    int   n;
    exp_t e;
    n = 0;
    ms_to_ws_valid = 1'b1;
    ms_to_ws_bus   = {32'h8000_0000 + data, be, dest, data};
    @(negedge clk);
    while (!ws_allowin && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ws_allowin) begin
      chk("accept_timeout", 64'd0, 64'd1);
      ms_to_ws_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (dest != 5'd0 && be != 4'd0) begin
      e.be   = be;
      e.addr = dest;
      e.data = data;
      e.pc   = 32'h8000_0000 + data;
      e.lat  = lat;
      e.acc  = ncyc;
      sb.push_back(e);
    end
    ms_to_ws_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] c;
    resetn = 1'b0;
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus = '0;
    rf_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("reset_allowin", {63'd0, ws_allowin}, 64'd1);
    chk("reset_cnt", {32'd0, ws_retire_cnt}, 64'd0);
    chk("reset_we", {63'd0, rf_we}, 64'd0);
    chk("reset_ds_valid", {63'd0, ws_to_ds_valid}, 64'd0);

    // Streaming at full rate
    @(posedge clk); #1;
    rf_ready = 1'b1;
    send(5'd1, 4'hF, 32'h11, 1'b1);
    send(5'd2, 4'hF, 32'h22, 1'b1);
    send(5'd3, 4'hF, 32'h33, 1'b1);
    send(5'd4, 4'hF, 32'h44, 1'b1);
    repeat (2) @(negedge clk);
    chk("stream_cnt", {32'd0, ws_retire_cnt}, 64'd4);
    chk("stream_sb_empty", sb.size(), 64'd0);

    // Stall: two entries held, third waits for space
    @(posedge clk); #1;
    rf_ready = 1'b0;
    fork
      begin
        send(5'd5, 4'hF, 32'h55, 1'b0);
        send(5'd6, 4'h3, 32'h66, 1'b0);
        send(5'd7, 4'hC, 32'h77, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        chk("stall_allowin", {63'd0, ws_allowin}, 64'd0);
        chk("stall_cnt", {32'd0, ws_retire_cnt}, 64'd4);
        chk("stall_head_dest", {59'd0, ws_to_ds_dest}, 64'd5);
        rf_ready = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    chk("stall_cnt_after", {32'd0, ws_retire_cnt}, 64'd7);
    chk("stall_sb_empty", sb.size(), 64'd0);

    // Register 0 write is suppressed and retires without the port
    @(posedge clk); #1;
    rf_ready = 1'b0;
    c = ws_retire_cnt;
    send(5'd0, 4'hF, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    chk("dest0_we", {63'd0, rf_we}, 64'd0);
    chk("dest0_ds_valid", {63'd0, ws_to_ds_valid}, 64'd1);
    chk("dest0_ds_dest", {59'd0, ws_to_ds_dest}, 64'd0);
    @(negedge clk);
    chk("dest0_cnt", {32'd0, ws_retire_cnt}, {32'd0, c + 32'd1});
    chk("dest0_retired", {63'd0, ws_to_ds_valid}, 64'd0);

    // be == 0 with a real dest also bypasses the port
    @(posedge clk); #1;
    send(5'd9, 4'h0, 32'h99, 1'b0);
    repeat (2) @(negedge clk);
    chk("be0_cnt", {32'd0, ws_retire_cnt}, {32'd0, c + 32'd2});

    // Reset while H and S are both full discards them
    @(posedge clk); #1;
    send(5'd10, 4'hF, 32'hAA, 1'b0);
    send(5'd11, 4'hF, 32'hBB, 1'b0);
    @(negedge clk);
    chk("full_allowin", {63'd0, ws_allowin}, 64'd0);
    resetn = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_full_ds_valid", {63'd0, ws_to_ds_valid}, 64'd0);
    chk("rst_full_allowin", {63'd0, ws_allowin}, 64'd1);
    chk("rst_full_cnt", {32'd0, ws_retire_cnt}, 64'd0);
    rf_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_full_no_commit", {32'd0, ws_retire_cnt}, 64'd0);

    // Counter wrap from a forced all-ones value
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1 release dut.retire_cnt;
    @(negedge clk);
    chk("wrap_preload", {32'd0, ws_retire_cnt}, 64'hFFFF_FFFF);
    @(posedge clk); #1;
    send(5'd12, 4'h1, 32'hC3, 1'b0);
    repeat (2) @(negedge clk);
    chk("wrap_cnt", {32'd0, ws_retire_cnt}, 64'd0);

    chk("final_sb_empty", sb.size(), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/wb_stage_pbuf.md
# wb_stage_pbuf

Parametrised write-back stage: accepts retired instructions from the memory stage, holds them in a two-entry head/skid buffer, and drives a byte-enabled register-file write port that can back-pressure via `rf_ready`. Successor to the fixed-width write-back stage. Adds configurable data, address and PC widths, a registered `ws_allowin`, suppression of writes to register 0, and a retired-instruction counter. Sits between the memory stage and the register file, and also supplies the decode stage's write-back hazard/bypass view plus the trace debug interface.

## Interface
- `DATA_W`, 32: register data width; multiple of 8.
- `REG_AW`, 5: register index width.
- `PC_W`, 32: PC width.
- `BE_W`, DATA_W/8: byte-enable width (derived; do not override).
- `BUS_W`, PC_W+BE_W+REG_AW+DATA_W: input bus width (derived).
- `clk`  in  1: clock.
- `resetn`  in  1: synchronous active-low reset.
- `ms_to_ws_valid`  in  1: memory stage offers an entry.
- `ms_to_ws_bus`  in  BUS_W: {pc, be, dest, result}, MSB first.
- `ws_allowin`  out  1: stage can accept an entry this cycle.
- `rf_ready`  in  1: register-file port accepts a write this cycle.
- `ws_to_rf_bus`  out  1+BE_W+REG_AW+DATA_W: {we, be, addr, data}.
- `ws_to_ds_valid`  out  1: head entry valid.
- `ws_to_ds_dest`  out  REG_AW: head dest; 0 when head writes nothing.
- `ws_to_ds_data`  out  DATA_W: head result (bypass).
- `ws_retire_cnt`  out  32: count of committed entries.
- `debug_wb_pc`  out  PC_W: committing PC.
- `debug_wb_rf_wen`  out  BE_W: committing byte enables.
- `debug_wb_rf_wnum`  out  REG_AW: committing dest.
- `debug_wb_rf_wdata`  out  DATA_W: committing data.

## Operation
- Storage: head register (H) and skid register (S), each with a valid bit.
- Effective byte enable: `be` from bus, forced to 0 when `dest == 0`. The forced value is applied at capture.
- Accept: `ms_to_ws_valid && ws_allowin`. `ws_allowin = !S.valid`, taken straight from a flop, with no combinational path from `rf_ready`.
- Commit condition: `H.valid && (rf_ready || H.be == 0)`. Entries that write no bytes retire without waiting for the port.
- `ws_to_rf_bus.we` = commit condition AND `H.be != 0`. The `be`, `addr` and `data` fields come from H.
- H update at each edge:
  - If H is empty or committing: load S if S is valid (S clears), else load the input if accepted, else clear H.valid.
  - Otherwise H holds.
- S update at each edge: an accepted input goes to S when H is held, or when S is being drained into H in the same edge.
- Ordering is strictly FIFO. S is never loaded while already valid.
- `ws_retire_cnt` increments by 1 on every commit and wraps modulo 2^32.
- `ws_to_ds_*` reflect H every cycle, whether or not it commits.

## Timing
- Reset (`resetn == 0` at a rising edge):
  - H.valid, S.valid and `ws_retire_cnt` go to 0.
  - `ws_allowin` = 1 after reset.
  - All rf, ds and debug outputs read 0.
  - Reset overrides any simultaneous accept or commit, and in-flight entries are discarded.
- Latency: an entry accepted at edge N appears on `ws_to_rf_bus` during cycle N+1, and commits at edge N+1 if `rf_ready` is high.
- Throughput: 1 entry/cycle while `rf_ready` stays high. S stays empty in steady state.
- Stall: with `rf_ready` low, the first entry sits in H and the second fills S. `ws_allowin` falls in the cycle after S fills.
- Simultaneous S→H drain and input accept in the same edge: the input lands in S.
- Entry with `be == 0` or `dest == 0`: `we = 0`, retires in 1 cycle regardless of `rf_ready`, and still increments the counter.

## Configuration
- Macro `WB_TRACE_EN`.
- Defined: `debug_wb_*` show H fields during cycles where the commit condition holds, and 0 otherwise.
- Undefined: all `debug_wb_*` ports are tied to 0 and no trace logic is synthesised. The ports remain present.

## Test plan
- Reset with `resetn = 0` for 2 cycles, then release → `ws_allowin = 1`, `ws_retire_cnt = 0`, `we = 0`.
- Streaming: 4 back-to-back entries (dest 1..4, be 0xF, data 0x11..0x44), `rf_ready = 1` → 4 writes in consecutive cycles, each 1 cycle after its accept; counter = 4.
- Stall: `rf_ready = 0` for 3 cycles while 3 entries are offered → 2 held, `ws_allowin = 0` and the third waits. After `rf_ready = 1`, writes come out in order and none is lost.
- Dest 0 with be 0xF, data 0xDEADBEEF, and `rf_ready = 0` → `we = 0`, entry retires in 1 cycle, counter increments.
- Reset asserted while both H and S are full → next cycle shows `ws_to_ds_valid = 0` and `ws_allowin = 1`, and no write of the discarded entries occurs.
- Counter wrap: preload the count to 0xFFFFFFFF via 2^32−1 commits or a forced initial value, then commit once → counter = 0.
